shbus_arbiter: RTL and testbench
================================

# shbus_arbiter

Arbitrates two masked-data producers (e.g. key loader and plaintext loader) onto one shared sharing port. Inputs arrive in bus representation (bit-major: bit i share j at index d*i+j). The output is registered in shares representation (share-major: share j bit i at index count*j+i), converted with the existing shbus2shares wiring. Grants are burst-locked and round-robin, so a multi-beat transaction (e.g. a 128-bit key as 4×32-bit beats) is never interleaved with the other requester.

## Interface
- d, 2, number of shares
- count, 8, bits per share per beat
- burst, 4, beats per granted transaction (≥1)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- req0_shbus  in  d*count  requester 0 beat, bus representation
- req0_valid  in  1  requester 0 beat valid
- req0_ready  out  1  requester 0 beat accepted when high with valid
- req1_shbus  in  d*count  requester 1 beat, bus representation
- req1_valid  in  1  requester 1 beat valid
- req1_ready  out  1  requester 1 beat accepted
- out_shares  out  d*count  registered beat, shares representation
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- out_src  out  1  requester index of the current output beat
- out_last  out  1  high on the final beat (beat burst-1) of a transaction

## Operation
- States: IDLE, GRANT0, GRANT1. Reset state is IDLE.
- Priority pointer `last` (1 bit): resets to 1, so requester 0 wins the first tie.
- IDLE:
  - If exactly one reqX_valid is high, go to GRANTX.
  - If both are high, go to GRANT(!last).
  - If neither is high, stay in IDLE.
  - Both readies are 0 in IDLE.
- GRANTX:
  - reqX_ready = out_ready | !out_valid. The other ready is 0.
  - Input handshake (reqX_valid & reqX_ready):
    - load out_shares with the converted reqX_shbus;
    - set out_valid=1, out_src=X, out_last=(beat_cnt==burst-1);
    - increment beat_cnt.
  - On the handshake of beat burst-1: beat_cnt←0, last←X, state←IDLE.
  - Grant is held until burst beats are accepted, regardless of the other requester.
- beat_cnt width is max(1,$clog2(burst)). It counts 0..burst-1 and never wraps past burst-1.
- Output register:
  - If out_valid&out_ready with no new load in the same cycle, clear out_valid.
  - A load in the same cycle as an output handshake replaces the beat (full throughput).
  - out_shares, out_src and out_last hold their value while out_valid&!out_ready.
- Requesters must keep valid high and data stable until accepted. A valid that drops mid-burst stalls the burst; it does not abort it.
- Reset (any time, including mid-burst) asynchronously returns:
  - state IDLE, beat_cnt 0, last 1;
  - out_valid 0, out_shares 0, out_src 0, out_last 0;
  - readies 0.
  - A partially transferred burst is discarded. No beat is emitted from it after reset.

## Timing
- Reset values: all outputs 0.
- Arbitration: 1 cycle (IDLE→GRANT). The ready of the granted requester rises in the first GRANT cycle.
- Input-to-output latency: 1 cycle (out_valid in the cycle after the input handshake).
- Throughput with out_ready=1: 1 beat/cycle inside a burst. One transaction occupies burst+1 cycles, including the single IDLE bubble between bursts.
- The readies are combinational from out_ready and out_valid. There is no combinational path from reqX_valid to any ready.

## Test plan
- Reset: assert rst asynchronously mid-cycle → out_valid=0, out_shares=16'h0000, req0_ready=req1_ready=0 immediately.
- Conversion (d=2,count=8): req0 alone sends 16'h0002 → out_shares=16'h0100, out_src=0. Sending 16'h0001 → 16'h0001. Sending 16'hAAAA → 16'hFF00.
- Tie after reset: both valid continuously, out_ready=1.
  - Output: 4 beats with out_src=0 (out_last on the 4th), one bubble, then 4 beats with out_src=1, then out_src=0 again.
- Backpressure: out_ready=0 while out_valid=1 → granted ready=0; out_shares, out_src and out_last stable for 5 cycles. Releasing out_ready delivers the beats in order with no loss or duplication.
- Reset mid-burst: after 2 of 4 req1 beats, pulse rst.
  - Next transaction with both valid is granted to req0 (last=1), starting at beat_cnt 0.
  - out_last appears only on its 4th beat.
- burst=1: both valid → out_src alternates 0,1,0,1, with out_last=1 on every beat and one bubble between beats.

Source files
------------

// File: rtl/shbus_arbiter.sv
// Two-requester, burst-locked round-robin arbiter onto one shared sharing port.
// Beats enter in bus (bit-major) order and leave registered in shares (share-major) order.
module shbus_arbiter #(
  parameter int d     = 2,
  parameter int count = 8,
  parameter int burst = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [d*count-1:0]   req0_shbus,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [d*count-1:0]   req1_shbus,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  output logic [d*count-1:0]   out_shares,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_src,
  output logic                 out_last
);

  localparam int W  = d * count;
  localparam int BW = (burst > 1) ? $clog2(burst) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(burst - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t          state_q;
  logic [BW-1:0]   beat_cnt_q;
  logic            last_q;
  logic            out_valid_q;
  logic            out_src_q;
  logic            out_last_q;
  logic [W-1:0]    out_shares_q;
  logic [W-1:0]    out_shares_d;

  // Bus bit i share j (index d*i+j) moves to share j bit i (index count*j+i).
  function automatic logic [W-1:0] shbus2shares(input logic [W-1:0] bus);
    logic [W-1:0] sh;
    sh = '0;
    for (int i = 0; i < count; i++) begin
      for (int j = 0; j < d; j++) begin
        sh[count*j + i] = bus[d*i + j];
      end
    end
    return sh;
  endfunction

  logic out_free;
  logic load0, load1, load;
  logic beat_last;

  // The output slot is free when empty or draining this cycle; no path from reqX_valid.
  assign out_free   = out_ready | ~out_valid_q;
  assign req0_ready = (state_q == GRANT0) & out_free;
  assign req1_ready = (state_q == GRANT1) & out_free;

  assign load0        = req0_valid & req0_ready;
  assign load1        = req1_valid & req1_ready;
  assign load         = load0 | load1;
  assign beat_last    = (beat_cnt_q == LAST_BEAT);
  assign out_shares_d = shbus2shares(load1 ? req1_shbus : req0_shbus);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      last_q       <= 1'b1;
      out_valid_q  <= 1'b0;
      out_shares_q <= '0;
      out_src_q    <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_valid && req1_valid) state_q <= last_q ? GRANT0 : GRANT1;
          else if (req0_valid)          state_q <= GRANT0;
          else if (req1_valid)          state_q <= GRANT1;
        end
        GRANT0, GRANT1: begin
          // Grant stays locked until the final beat of the burst is accepted.
          if (load) begin
            if (beat_last) begin
              beat_cnt_q <= '0;
              last_q     <= load1;
              state_q    <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (load) begin
        out_valid_q  <= 1'b1;
        out_shares_q <= out_shares_d;
        out_src_q    <= load1;
        out_last_q   <= beat_last;
      end else if (out_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_shares = out_shares_q;
  assign out_src    = out_src_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_shbus_arbiter.sv
// Directed bench for shbus_arbiter: conversion, tie round-robin, backpressure,
// reset behaviour, and a burst=1 instance.
module tb_shbus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req0_shbus, req1_shbus;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] out_shares;
  logic        out_valid, out_ready, out_src, out_last;

  logic [15:0] b_req0_shbus, b_req1_shbus;
  logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic [15:0] b_out_shares;
  logic        b_out_valid, b_out_ready, b_out_src, b_out_last;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shbus_arbiter #(.d(2), .count(8), .burst(4)) u_dut (
    .clk(clk), .rst(rst),
    .req0_shbus(req0_shbus), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_shbus(req1_shbus), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .out_shares(out_shares), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_last(out_last)
  );

  shbus_arbiter #(.d(2), .count(8), .burst(1)) u_dut_b1 (
    .clk(clk), .rst(rst),
    .req0_shbus(b_req0_shbus), .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
    .req1_shbus(b_req1_shbus), .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
    .out_shares(b_out_shares), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_src(b_out_src), .out_last(b_out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output per cycle of the tie sequence (cycle 1 = arbitration cycle).
  logic        tie_ov  [1:12] = '{0, 1,1,1,1, 0, 1,1,1,1, 0, 1};
  logic        tie_src [1:12] = '{0, 0,0,0,0, 0, 1,1,1,1, 0, 0};
  logic        tie_last[1:12] = '{0, 0,0,0,1, 0, 0,0,0,1, 0, 0};
  logic [15:0] bp_data [0:3]  = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
  logic [15:0] bp_exp  [0:3]  = '{16'h0001, 16'h0100, 16'h0002, 16'h0200};

  initial begin
    rst = 1'b1;
    req0_shbus = '0; req1_shbus = '0; req0_valid = 0; req1_valid = 0; out_ready = 0;
    b_req0_shbus = 16'h0003; b_req1_shbus = 16'h000C;
    b_req0_valid = 0; b_req1_valid = 0; b_out_ready = 0;
    #12;
    check("rst_ov", out_valid, 0);
    check("rst_shares", out_shares, 16'h0000);
    check("rst_src_last", {out_src, out_last}, 0);
    check("rst_rdy", {req0_ready, req1_ready}, 0);

    // Conversion: req0 alone, data advances on each accepted beat.
    tick(); rst = 0;
    req0_valid = 1; req0_shbus = 16'h0002; out_ready = 1;
    tick();
    check("arb_rdy0", req0_ready, 1);
    check("arb_rdy1", req1_ready, 0);
    check("arb_ov", out_valid, 0);
    tick();
    check("conv_0002", out_shares, 16'h0100);
    check("conv_src", out_src, 0);
    check("conv_ov", out_valid, 1);
    check("conv_last0", out_last, 0);
    req0_shbus = 16'h0001;
    tick(); check("conv_0001", out_shares, 16'h0001);
    req0_shbus = 16'hAAAA;
    tick(); check("conv_AAAA", out_shares, 16'hFF00);
    req0_shbus = 16'h5555;
    tick(); check("conv_5555", out_shares, 16'h00FF);
    check("conv_last", out_last, 1);
    req0_valid = 0;
    tick(); check("conv_drain", out_valid, 0);
    check("idle_rdy", {req0_ready, req1_ready}, 0);

    // Async reset mid-cycle while a beat is held in the output register.
    req0_valid = 1; req0_shbus = 16'h1234;
    tick(); tick();
    check("pre_rst_ov", out_valid, 1);
    #3 rst = 1;
    #1;
    check("arst_ov", out_valid, 0);
    check("arst_shares", out_shares, 16'h0000);
    check("arst_rdy", {req0_ready, req1_ready}, 0);
    check("arst_src_last", {out_src, out_last}, 0);
    req0_valid = 0;
    tick(); rst = 0;

    // Tie after reset: req0 first, bubble, req1, bubble, req0.
    req0_shbus = 16'h0003; req1_shbus = 16'h000C;
    req0_valid = 1; req1_valid = 1; out_ready = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("tie_ov%0d", k), out_valid, tie_ov[k]);
      if (tie_ov[k]) begin
        check($sformatf("tie_src%0d", k), out_src, tie_src[k]);
        check($sformatf("tie_last%0d", k), out_last, tie_last[k]);
        check($sformatf("tie_data%0d", k), out_shares, tie_src[k] ? 16'h0202 : 16'h0101);
      end
    end
    req0_valid = 0; req1_valid = 0;
    rst = 1; tick(); rst = 0;

    // Backpressure: hold the first beat for 5 cycles, then drain in order.
    req0_valid = 1; req0_shbus = bp_data[0];
    tick(); tick();
    check("bp_b0", out_shares, bp_exp[0]);
    out_ready = 0; req0_shbus = bp_data[1];
    #1 check("bp_rdy_low", req0_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold%0d", k), {out_valid, out_src, out_last, out_shares},
            {1'b1, 1'b0, 1'b0, bp_exp[0]});
      check($sformatf("bp_rdy%0d", k), req0_ready, 0);
    end
    out_ready = 1;
    #1 check("bp_rdy_high", req0_ready, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("bp_b%0d", k), out_shares, bp_exp[k]);
      check($sformatf("bp_last%0d", k), out_last, (k == 3));
      if (k < 3) req0_shbus = bp_data[k+1];
    end
    req0_valid = 0;
    tick(); check("bp_drain", out_valid, 0);

    // Reset after 2 of 4 req1 beats; req0 then wins the tie from beat 0.
    req1_valid = 1; req1_shbus = 16'h000C;
    tick(); check("mr_grant1", req1_ready, 1);
    tick(); tick();
    check("mr_src1", out_src, 1);
    #3 rst = 1;
    #2 rst = 0;
    check("mr_ov", out_valid, 0);
    req0_valid = 1; req0_shbus = 16'h0003;
    tick(); check("mr_arb", {req0_ready, req1_ready}, 2'b10);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("mr_src%0d", k), {out_valid, out_src}, 2'b10);
      check($sformatf("mr_last%0d", k), out_last, (k == 3));
    end
    req0_valid = 0; req1_valid = 0;
    tick();

    // burst=1 instance: alternating single-beat grants with bubbles.
    b_req0_valid = 1; b_req1_valid = 1; b_out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("b1_ov%0d", k), b_out_valid, (k % 2 == 0));
      if (k % 2 == 0) begin
        check($sformatf("b1_src%0d", k), b_out_src, (k % 4 == 0));
        check($sformatf("b1_last%0d", k), b_out_last, 1);
      end
    end
    b_req0_valid = 0; b_req1_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
